// File: rtl/uhci_access_arbiter.sv
// Serialises FIFO-sourced writes and single front-end reads onto the shared
// UHCI register-file / USB packet-memory port, returning read data by toggle.
module uhci_access_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int Data_W     = 32,
    parameter int usb_mem_W  = 6,
    parameter int MEM_RD_LAT = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [ADDR_W-1:0]    fifo_addr,
    input  logic [Data_W-1:0]    fifo_data,
    input  logic                 rd_req,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic                 uhci_busy,
    output logic                 reg_we,
    output logic                 reg_re,
    output logic [7:0]           reg_addr,
    output logic [7:0]           reg_wdata,
    input  logic [7:0]           reg_rdata,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic [usb_mem_W-1:0] mem_addr,
    output logic [Data_W-1:0]    mem_wdata,
    input  logic [Data_W-1:0]    mem_rdata,
    output logic [7:0]           r_data_reg,
    output logic [Data_W-1:0]    r_data_mem,
    output logic                 data_reg_toggle,
    output logic                 data_mem_toggle,
    output logic                 acc_err
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_POP      = 3'd1;
    localparam logic [2:0] ST_WR       = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_WAIT  = 3'd4;
    localparam logic [2:0] ST_RD_DONE  = 3'd5;

    localparam logic [2:0] LAT_LAST = 3'(MEM_RD_LAT);

    // Memory window is addr[usb_mem_W+1:2]; any set bit above it up to bit 9 is out of range.
    function automatic logic mem_oor(input logic [9:0] a);
        return (a >> (usb_mem_W + 2)) != 10'd0;
    endfunction

    logic [2:0] state_r;
    logic [2:0] next_state_s;
    logic       start_rd_s;
    logic       rd_last_s;
    logic       armed_r;
    logic       rd_is_reg_r;
    logic       rd_oor_r;
    logic [2:0] wait_cnt_r;
    logic       unused_bits_s;

    assign unused_bits_s = ^{fifo_addr[ADDR_W-1:11], rd_addr[ADDR_W-1:11]};

    // Next-state decode; writes win over reads and busy only gates new starts.
    always_comb begin
        next_state_s = state_r;
        start_rd_s   = 1'b0;
        rd_last_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (uhci_busy) begin
                    next_state_s = ST_IDLE;
                end else if (!fifo_empty) begin
                    next_state_s = ST_POP;
                end else if (rd_req && armed_r) begin
                    next_state_s = ST_RD_ISSUE;
                    start_rd_s   = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_POP:      next_state_s = ST_WR;
            ST_WR: begin
                if (!fifo_empty && !uhci_busy) begin
                    next_state_s = ST_POP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD_ISSUE: next_state_s = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (rd_is_reg_r || (wait_cnt_r == LAT_LAST)) begin
                    next_state_s = ST_RD_DONE;
                    rd_last_s    = 1'b1;
                end else begin
                    next_state_s = ST_RD_WAIT;
                end
            end
            ST_RD_DONE:  next_state_s = ST_IDLE;
            default:     next_state_s = ST_IDLE;
        endcase
    end

    // Sequencing state: FSM, read re-arm, latched read target and latency counter.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r     <= ST_IDLE;
            armed_r     <= 1'b1;
            rd_is_reg_r <= 1'b0;
            rd_oor_r    <= 1'b0;
            wait_cnt_r  <= 3'd0;
        end else begin
            state_r <= next_state_s;
            if (!rd_req) begin
                armed_r <= 1'b1;
            end else if (start_rd_s) begin
                armed_r <= 1'b0;
            end
            if (start_rd_s) begin
                rd_is_reg_r <= rd_addr[10];
                rd_oor_r    <= !rd_addr[10] && mem_oor(rd_addr[9:0]);
            end
            if (state_r == ST_RD_ISSUE) begin
                wait_cnt_r <= 3'd1;
            end else if (state_r == ST_RD_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 3'd1;
            end
        end
    end

    // Registered port outputs; the FIFO head is captured on the edge that pops it.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fifo_rd_en      <= 1'b0;
            reg_we          <= 1'b0;
            reg_re          <= 1'b0;
            mem_we          <= 1'b0;
            mem_re          <= 1'b0;
            acc_err         <= 1'b0;
            reg_addr        <= 8'd0;
            reg_wdata       <= 8'd0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            r_data_reg      <= 8'd0;
            r_data_mem      <= '0;
            data_reg_toggle <= 1'b0;
            data_mem_toggle <= 1'b0;
        end else begin
            fifo_rd_en <= (next_state_s == ST_POP);
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            acc_err    <= 1'b0;
            if (state_r == ST_POP) begin
                reg_addr  <= fifo_addr[7:0];
                reg_wdata <= fifo_data[7:0];
                mem_addr  <= fifo_addr[usb_mem_W+1:2];
                mem_wdata <= fifo_data;
                if (fifo_addr[10]) begin
                    reg_we <= 1'b1;
                end else if (mem_oor(fifo_addr[9:0])) begin
                    acc_err <= 1'b1;
                end else begin
                    mem_we <= 1'b1;
                end
            end
            if (start_rd_s) begin
                reg_addr <= rd_addr[7:0];
                mem_addr <= rd_addr[usb_mem_W+1:2];
                if (rd_addr[10]) begin
                    reg_re <= 1'b1;
                end else if (!mem_oor(rd_addr[9:0])) begin
                    mem_re <= 1'b1;
                end
            end
            // Data and toggle move on the same edge so the consumer sees them together.
            if (rd_last_s) begin
                if (rd_is_reg_r) begin
                    r_data_reg      <= reg_rdata;
                    data_reg_toggle <= ~data_reg_toggle;
                end else begin
                    r_data_mem      <= rd_oor_r ? '0 : mem_rdata;
                    data_mem_toggle <= ~data_mem_toggle;
                    acc_err         <= rd_oor_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_uhci_access_arbiter.sv
// Directed bench for uhci_access_arbiter: FIFO/memory/register models around the
// DUT, per-cycle checks against hand-computed values.
module tb_uhci_access_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_addr;
    logic [31:0] fifo_data;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        uhci_busy;
    logic        reg_we, reg_re, mem_we, mem_re;
    logic [7:0]  reg_addr, reg_wdata, reg_rdata;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [7:0]  r_data_reg;
    logic [31:0] r_data_mem;
    logic        data_reg_toggle, data_mem_toggle, acc_err;

    int n_chk = 0;
    int n_bad = 0;

    logic [63:0] fq[$];
    logic [1:0]  re_pipe  = 2'b00;
    logic        reg_re_d = 1'b0;
    logic [31:0] mem_val  = 32'hCAFE_F00D;

    always #5 Clk = ~Clk;

    uhci_access_arbiter #(
        .ADDR_W(32), .Data_W(32), .usb_mem_W(6), .MEM_RD_LAT(2)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_addr(fifo_addr), .fifo_data(fifo_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .uhci_busy(uhci_busy),
        .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .r_data_reg(r_data_reg), .r_data_mem(r_data_mem),
        .data_reg_toggle(data_reg_toggle), .data_mem_toggle(data_mem_toggle),
        .acc_err(acc_err)
    );

    // Memory answers MEM_RD_LAT=2 cycles after mem_re, register one cycle after reg_re.
    always @(posedge Clk) begin
        re_pipe  <= {re_pipe[0], mem_re};
        reg_re_d <= reg_re;
    end
    assign mem_rdata = re_pipe[1] ? mem_val : 32'hDEAD_BEEF;
    assign reg_rdata = reg_re_d ? 8'h5C : 8'hEE;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic upd_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_addr  = fifo_empty ? 32'd0 : fq[0][63:32];
        fifo_data  = fifo_empty ? 32'd0 : fq[0][31:0];
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        fq.push_back({a, d});
        upd_fifo();
    endtask

    // Advance one cycle; the head is removed on the edge that sees fifo_rd_en high.
    task automatic tick();
        logic popped;
        popped = fifo_rd_en;
        @(posedge Clk);
        #1;
        if (popped && fq.size() > 0) void'(fq.pop_front());
        upd_fifo();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_strb"}, {fifo_rd_en, reg_we, reg_re, mem_we, mem_re, acc_err,
                               data_reg_toggle, data_mem_toggle}, 64'd0);
        check({tag, "_addr"}, {reg_addr, reg_wdata, mem_addr}, 64'd0);
        check({tag, "_wdat"}, {32'd0, mem_wdata}, 64'd0);
        check({tag, "_rdat"}, {24'd0, r_data_reg, r_data_mem}, 64'd0);
    endtask

    initial begin
        int cnt;
        Rst = 1'b0; rd_req = 1'b0; rd_addr = 32'd0; uhci_busy = 1'b0;
        upd_fifo();
        tick(); tick();
        check_zero("reset");
        Rst = 1'b1;
        tick();

        // Single register write
        push(32'h0000_0404, 32'h0000_00A5);
        tick();
        check("rw_pop", {fifo_rd_en, reg_we}, 64'b10);
        tick();
        check("rw_we", {fifo_rd_en, reg_we, mem_we}, 64'b010);
        check("rw_ad", {reg_addr, reg_wdata}, 64'h04A5);
        tick();
        check("rw_end", {fifo_rd_en, reg_we}, 64'b00);

        // Burst of three memory writes, one per two cycles
        push(32'h0, 32'h11); push(32'h4, 32'h22); push(32'h8, 32'h33);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bw_pop", {fifo_rd_en, mem_we}, 64'b10);
            tick();
            check("bw_we", {fifo_rd_en, mem_we, reg_we}, 64'b010);
            check("bw_ad", {mem_addr, mem_wdata}, {26'd0, 6'(k), 32'h11 * (k + 1)});
        end
        tick();
        check("bw_end", {fifo_rd_en, mem_we}, 64'b00);

        // Memory read of word 2, latency 2; rd_addr changes after acceptance
        rd_req = 1'b1; rd_addr = 32'h8;
        tick();
        check("mr_re", {mem_re, reg_re, mem_addr}, {2'b10, 6'd2});
        rd_addr = 32'h404;
        tick();
        check("mr_t2", {mem_re, data_mem_toggle}, 64'b00);
        tick();
        check("mr_t3", data_mem_toggle, 64'd0);
        tick();
        check("mr_dat", r_data_mem, 64'hCAFE_F00D);
        check("mr_tog", {data_mem_toggle, acc_err, data_reg_toggle}, 64'b100);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cnt += int'(mem_re) + int'(reg_re);
        end
        check("mr_once", cnt, 64'd0);
        rd_req = 1'b0;
        tick();

        // Pending write and read request together: write first
        push(32'h0000_0410, 32'h77);
        rd_req = 1'b1; rd_addr = 32'h0000_0408;
        tick();
        check("pr_pop", {fifo_rd_en, reg_re}, 64'b10);
        tick();
        check("pr_we", {reg_we, reg_re, reg_addr, reg_wdata}, {2'b10, 16'h1077});
        tick();
        check("pr_gap", {reg_we, reg_re}, 64'b00);
        tick();
        check("pr_re", {reg_we, reg_re, reg_addr}, {2'b01, 8'h08});
        tick();
        check("pr_wait", data_reg_toggle, 64'd0);
        tick();
        check("pr_dat", {data_reg_toggle, r_data_reg}, {1'b1, 8'h5C});
        rd_req = 1'b0;
        tick();

        // Busy holds the port for five cycles
        uhci_busy = 1'b1;
        push(32'h0000_000C, 32'h44);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bz_hold", fifo_rd_en, 64'd0);
        end
        uhci_busy = 1'b0;
        tick();
        check("bz_pop", fifo_rd_en, 64'd1);
        tick();
        check("bz_we", {mem_we, mem_addr, mem_wdata}, {1'b1, 6'd3, 32'h44});

        // Out-of-range memory write
        tick();
        push(32'h0000_0100, 32'h99);
        tick();
        check("ow_pop", fifo_rd_en, 64'd1);
        tick();
        check("ow_err", {mem_we, reg_we, acc_err}, 64'b001);
        tick();
        check("ow_end", {mem_we, acc_err}, 64'b00);

        // Out-of-range memory read
        rd_req = 1'b1; rd_addr = 32'h0000_0100;
        tick();
        check("or_nore", {mem_re, reg_re}, 64'b00);
        tick(); tick();
        check("or_t3", {data_mem_toggle, acc_err}, 64'b10);
        tick();
        check("or_dat", r_data_mem, 64'd0);
        check("or_tog", {data_mem_toggle, acc_err}, 64'b01);
        tick();
        check("or_end", acc_err, 64'd0);
        rd_req = 1'b0;
        tick();

        // Reset during RD_WAIT
        rd_req = 1'b1; rd_addr = 32'h8;
        tick();
        check("rs_re", mem_re, 64'd1);
        tick();
        Rst = 1'b0;
        #1;
        check_zero("rs_mid");
        rd_req = 1'b0;
        tick(); tick();
        Rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt += int'(mem_re) + int'(reg_re) + int'(data_mem_toggle);
        end
        check("rs_quiet", cnt, 64'd0);

        // Register read after reset proves re-arm and toggle restart
        rd_req = 1'b1; rd_addr = 32'h0000_0404;
        tick();
        check("rr_re", {reg_re, reg_addr}, {1'b1, 8'h04});
        tick();
        tick();
        check("rr_dat", {data_reg_toggle, r_data_reg}, {1'b1, 8'h5C});
        rd_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
